uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Write side of the instruction memory. Ifetc32 only reads program ROM; this block fills it.
- Receives a program image as a UART byte stream (8N1) while programming mode is active.
- Packs every four bytes into a 32-bit instruction word and writes it to consecutive word addresses from 0.
- Signals completion so the CPU can be released from reset and begin fetching at PC 0.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit period (100 MHz / 115200)
ADDR_WIDTH, 14, word-address width of instruction memory (16K words)
IDLE_CLKS, 1000000, idle cycles after the last received byte that end the load

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state
prog_en  in  1  programming mode; loader runs only while high
rx  in  1  UART serial input, idle high, asynchronous to clock
wr_en  out  1  one-cycle write strobe to instruction memory
wr_addr  out  ADDR_WIDTH  word address of the write
wr_data  out  32  instruction word to write
word_count  out  ADDR_WIDTH+1  number of words written since load start
done  out  1  load complete; level, held until prog_en falls or reset
frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- The clock port is named clock; the reset port is named reset.

Reset values:
- wr_en=0, wr_addr=0, wr_data=0, word_count=0, done=0, frame_err=0.
- rx synchronizer flops=1; RX FSM=IDLE; byte index=0; idle counter=0.

prog_en:
- prog_en=0 holds every register at its reset value on each clock. This is the same as reset; done clears.
- A rising prog_en starts a fresh load at address 0.

rx input:
- rx passes through a 2-flop synchronizer. Only the synchronized value is used.

RX FSM (states IDLE, START, DATA, STOP, DONE):
- IDLE: synchronized rx=0 -> START and clear the bit counter.
- START: wait CLKS_PER_BIT/2 cycles, then sample. Sample 0 -> DATA. Sample 1 is a glitch -> IDLE, no error.
- DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first. After bit 7 -> STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1 -> byte valid, go to IDLE.
  - Sample 0 -> frame_err pulses for 1 cycle, the byte is discarded, the byte index resets to 0 (partial word dropped), go to IDLE.
- DONE: ignore rx entirely until prog_en falls or reset.

Word assembly:
- Byte order is big-endian. Byte index 0 -> wr_data[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
- On the valid 4th byte:
  - wr_en=1 for exactly one cycle, the cycle after the stop-bit sample.
  - wr_addr holds the current address; wr_data holds the full word.
  - The byte index returns to 0.
  - The address and word_count increment in the same cycle, so the new values appear the cycle after wr_en.
- wr_addr and wr_data are stable during the wr_en cycle and hold their values afterwards.

Idle timeout:
- The counter runs only when the FSM is in IDLE and word_count>0.
- It clears on any start-bit detect.
- On reaching IDLE_CLKS: done=1 and the FSM enters DONE.
- A partial word (1-3 bytes) pending at timeout is discarded, with no write.

Address full:
- After the write to address 2^ADDR_WIDTH-1: word_count=2^ADDR_WIDTH, done=1 the next cycle, FSM enters DONE.
- The address never wraps; no further writes occur.

Simultaneous and mid-operation events:
- Reset mid-frame, or prog_en falling mid-frame: the current byte and partial word are abandoned. The next load starts at address 0.
- Timeout and start-bit detect in the same cycle: the start bit wins and the counter clears.

Test Plan:
Bench settings: CLKS_PER_BIT=4, ADDR_WIDTH=4, IDLE_CLKS=64.
1. Send bytes 0x3C,0x01,0xFF,0xFF -> exactly one wr_en pulse with wr_addr=0, wr_data=0x3C01FFFF. word_count=1 the following cycle.
2. Send 8 bytes 0x00..0x07, then idle 64+ cycles -> writes (0,0x00010203) and (1,0x04050607). done=1 about 64 cycles after the last stop bit. Later rx traffic causes no writes.
3. Send 0xAA, 0xBB, then a frame with stop bit 0 -> one frame_err pulse, no write. Then send 0x11,0x22,0x33,0x44 -> write (0,0x11223344).
4. Pulse rx low for 1 cycle only -> no frame_err, no byte, no write; the FSM returns to IDLE.
5. Send 64 bytes -> 16 writes at addresses 0..15. done=1 the cycle after the 16th write, word_count=16. A 17th word produces no wr_en.
6. Assert reset after 2 bytes of a word, release it, then send 4 bytes -> a single write at address 0 with those 4 bytes; no leftover bytes appear.

Source files
------------

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver that packs big-endian bytes into
// instruction words and writes them to instruction memory from address 0.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14,
    parameter int IDLE_CLKS    = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_en,
    input  logic                  rx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  done,
    output logic                  frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_s1_q, rx_s1_d;
    logic                  rx_s2_q, rx_s2_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           word_q, word_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  done_q, done_d;
    logic                  frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        rx_s1_d      = rx;
        rx_s2_d      = rx_s1_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        idle_cnt_d   = idle_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start edge always beats a timeout landing in the same cycle.
                if (!rx_s2_q) begin
                    state_d    = S_START;
                    clk_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (word_count_q != '0) begin
                    if (idle_cnt_q == IW'(IDLE_CLKS - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rx_s2_q) begin
                        if (byte_idx_q == 2'd3) begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = {word_q, shift_q};
                            byte_idx_d = 2'd0;
                        end else begin
                            word_d     = {word_q[15:0], shift_q};
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = 2'd0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Address and count advance after the strobe; the last address never wraps.
        if (wr_en_q) begin
            word_count_d = word_count_q + 1'b1;
            if (wr_addr_q == ADDR_MAX) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !prog_en) begin
            state_q      <= S_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            idle_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx_s1_d;
            rx_s2_q      <= rx_s2_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            idle_cnt_q   <= idle_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign done       = done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader.
module tb_uart_prog_loader;

    localparam int CPB  = 4;
    localparam int AW   = 4;
    localparam int IDLE = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          prog_en = 1'b0;
    logic          rx = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   word_count;
    logic          done;
    logic          frame_err;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .IDLE_CLKS   (IDLE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .prog_en   (prog_en),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .word_count(word_count),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [AW+31:0] sb[$];
    logic [AW+31:0] sb_e;
    int exp_wc = 0;
    int fe_cnt = 0;
    bit wc_pend = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (wc_pend) begin
            check("word_count_after_wr", 64'(word_count), 64'(exp_wc));
            wc_pend = 1'b0;
        end
        if (frame_err) fe_cnt++;
        if (wr_en) begin
            check("wr_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                sb_e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(sb_e[AW+31:32]));
                check("wr_data", 64'(wr_data), 64'(sb_e[31:0]));
            end
            exp_wc++;
            wc_pend = 1'b1;
        end
        if (reset || !prog_en) exp_wc = 0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] data, input bit expect_wr);
        if (expect_wr) sb.push_back({addr, data});
        send_byte(data[31:24], 1'b1);
        send_byte(data[23:16], 1'b1);
        send_byte(data[15:8], 1'b1);
        send_byte(data[7:0], 1'b1);
    endtask

    task automatic start_load();
        rx = 1'b1;
        prog_en = 1'b0;
        tick(3);
        prog_en = 1'b1;
        fe_cnt = 0;
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        reset = 1'b0;

        // single word
        start_load();
        send_word(4'd0, 32'h3C01FFFF, 1'b1);
        tick(3);
        check("t1_drain", 64'(sb.size()), 64'd0);
        check("t1_wc", 64'(word_count), 64'd1);

        // two words then idle timeout
        start_load();
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) sb.push_back({AW'(i / 4), 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)});
            send_byte(8'(i), 1'b1);
        end
        tick(3);
        check("t2_drain", 64'(sb.size()), 64'd0);
        check("t2_done_early", 64'(done), 64'd0);
        tick(50);
        check("t2_done_before_timeout", 64'(done), 64'd0);
        tick(24);
        check("t2_done", 64'(done), 64'd1);
        send_word(4'd0, 32'h55667788, 1'b0);
        tick(3);
        check("t2_done_held", 64'(done), 64'd1);
        check("t2_wc_held", 64'(word_count), 64'd2);

        // framing error drops the partial word
        start_load();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        tick(8);
        check("t3_frame_err_cnt", 64'(fe_cnt), 64'd1);
        check("t3_wc", 64'(word_count), 64'd0);
        send_word(4'd0, 32'h11223344, 1'b1);
        tick(3);
        check("t3_drain", 64'(sb.size()), 64'd0);
        check("t3_frame_err_final", 64'(fe_cnt), 64'd1);

        // one-cycle glitch
        start_load();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check("t4_no_frame_err", 64'(fe_cnt), 64'd0);
        check("t4_wc", 64'(word_count), 64'd0);
        send_word(4'd0, 32'hDEADBEEF, 1'b1);
        tick(3);
        check("t4_drain", 64'(sb.size()), 64'd0);

        // fill the whole memory
        start_load();
        for (int w = 0; w < 16; w++) begin
            send_word(AW'(w), {8'(w), 8'hC3, 8'(w * 3), 8'h5A}, 1'b1);
        end
        tick(1);
        check("t5_done_during_last_wr", 64'(done), 64'd0);
        tick(1);
        check("t5_done", 64'(done), 64'd1);
        check("t5_wc", 64'(word_count), 64'd16);
        send_word(4'd0, 32'h0BADF00D, 1'b0);
        tick(3);
        check("t5_drain", 64'(sb.size()), 64'd0);
        check("t5_wc_final", 64'(word_count), 64'd16);
        check("t5_addr_no_wrap", 64'(wr_addr), 64'd15);

        // reset mid-word
        start_load();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        rx = 1'b0;
        tick(10);
        reset = 1'b1;
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        send_word(4'd0, 32'hCAFEF00D, 1'b1);
        tick(3);
        check("t6_drain", 64'(sb.size()), 64'd0);
        check("t6_wc", 64'(word_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
